// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one outstanding transaction.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise LSU has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                grant_lsu;
  logic                accept;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // requesters hold valid and fields until then, and ready never depends on a later cycle.
`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  always_comb begin
    grant_lsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) grant_lsu = (last_owner_q == OWN_IFU);
    last_owner_d = last_owner_q;
    if (accept) last_owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
  end

  // Reset to LSU so the first tie goes to the IFU.
  always_ff @(posedge clk) begin
    if (!rst) last_owner_q <= OWN_LSU;
    else      last_owner_q <= last_owner_d;
  end
`else
  always_comb grant_lsu = lsu_req_valid;
`endif

  always_comb accept = (state_q == ST_IDLE) && (ifu_req_valid || lsu_req_valid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
          if (grant_lsu) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wstrb_d = lsu_wstrb;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      ST_REQ:  if (mem_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_valid      = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ifu_req_ready = ifu_req_valid && !grant_lsu;
        lsu_req_ready = grant_lsu;
      end
      ST_REQ:  mem_valid = 1'b1;
      ST_WAIT: begin
        ifu_resp_valid = mem_rvalid && (owner_q == OWN_IFU);
        lsu_resp_valid = mem_rvalid && (owner_q == OWN_LSU);
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random IFU/LSU traffic against a transaction-level model,
// a randomly stalling slave, and directed reset / stray-response cases.
module tb_mem_arbiter;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [3:0]  dly_ready;
    logic [3:0]  dly_resp;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  dbg_state;

  logic        slave_en, slv_ready, slv_rvalid, man_ready, man_rvalid;
  logic [31:0] slv_rdata, man_rdata;
  assign mem_ready  = slave_en ? slv_ready  : man_ready;
  assign mem_rvalid = slave_en ? slv_rvalid : man_rvalid;
  assign mem_rdata  = slave_en ? slv_rdata  : man_rdata;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    finish_run();
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] slv_q[$];
  bit   mon_track = 0;
  bit   txn_open = 0;
  bit   rdy_seen;
  exp_t cur, slv_cur;
  int   acc_cyc, mv_cnt;
  int   acc_cnt = 0;
  int   done_cnt = 0;

  // Reference model: pending request per master plus last winner.
  bit          ifu_pend, lsu_pend;
  logic [31:0] ifu_a, lsu_a, lsu_d;
  logic        lsu_w;
  logic [3:0]  lsu_s;
  logic        last_owner;

  // ---------------- slave model ----------------
  initial begin
    slv_ready = 1'b0;
    slv_rvalid = 1'b0;
    slv_rdata = '0;
    forever begin
      @(negedge clk);
      slv_rdata = $urandom;
      if (slave_en && mem_valid) begin
        if (slv_q.size() == 0) begin
          failures++;
          $display("FAIL slave_request actual=unexpected required=none");
          finish_run();
        end
        slv_cur = slv_q.pop_front();
        for (int d = 0; d < int'(slv_cur.dly_ready); d++) begin
          slv_ready = 1'b0;
          @(negedge clk);
        end
        slv_ready = 1'b1;
        @(negedge clk);
        slv_ready = 1'b0;
        for (int l = 0; l < int'(slv_cur.dly_resp); l++) begin
          slv_rdata = $urandom;
          @(negedge clk);
        end
        slv_rvalid = 1'b1;
        slv_rdata = slv_cur.rdata;
        @(negedge clk);
        slv_rvalid = 1'b0;
        slv_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!mon_track) begin
        txn_open = 0;
        check("no_resp_untracked", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      end else if (txn_open) begin
        if (ifu_req_ready || lsu_req_ready) rdy_seen = 1;
        if (mem_valid) begin
          mv_cnt++;
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wen", mem_wen, cur.wen);
          check("mem_wstrb", mem_wstrb, cur.wstrb);
          if (cur.wen) check("mem_wdata", mem_wdata, cur.wdata);
        end
        if (ifu_resp_valid || lsu_resp_valid) begin
          check("resp_route", {ifu_resp_valid, lsu_resp_valid}, cur.owner ? 2'b01 : 2'b10);
          if (!(cur.owner && cur.wen))
            check("resp_rdata", cur.owner ? lsu_rdata : ifu_rdata, cur.rdata);
          check("resp_latency", cyc - acc_cyc, 2 + cur.dly_ready + cur.dly_resp);
          check("mem_valid_cycles", mv_cnt, cur.dly_ready + 1);
          check("no_ready_in_txn", rdy_seen, 0);
          txn_open = 0;
          done_cnt++;
        end
      end else begin
        check("quiet_outside_txn", {mem_valid, ifu_resp_valid, lsu_resp_valid}, 3'b000);
        if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_accept actual=accept required=none");
          end else begin
            cur = exp_q.pop_front();
            check("grant_owner", {ifu_req_valid && ifu_req_ready, lsu_req_valid && lsu_req_ready},
                  cur.owner ? 2'b01 : 2'b10);
            txn_open = 1;
            acc_cyc = cyc;
            mv_cnt = 0;
            rdy_seen = 0;
            acc_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    mon_track = 0;
    @(negedge clk);
    rst = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    ifu_pend = 0;
    lsu_pend = 0;
    exp_q.delete();
    slv_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_owner = OWN_LSU;
  endtask

  task automatic set_ifu(input logic [31:0] a);
    if (!ifu_pend) begin
      ifu_pend = 1;
      ifu_a = a;
      ifu_addr = a;
      ifu_req_valid = 1'b1;
    end
  endtask

  task automatic set_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s);
    if (!lsu_pend) begin
      lsu_pend = 1;
      lsu_a = a; lsu_w = w; lsu_d = d; lsu_s = s;
      lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_wstrb = s;
      lsu_req_valid = 1'b1;
    end
  endtask

  task automatic rand_lsu();
    set_lsu($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
  endtask

  // Predicts the winner, queues the expectation and waits for completion.
  task automatic run_one(input int dr, input int dl, input logic [31:0] rd);
    exp_t e;
    bit   win_lsu;
    int   n, tgt_acc, tgt_done;
    if (!ifu_pend && !lsu_pend) set_ifu($urandom & 32'hFFFF_FFFC);
    if (ifu_pend && lsu_pend) begin
`ifdef MEM_ARB_RR_EN
      win_lsu = (last_owner == OWN_IFU);
`else
      win_lsu = 1;
`endif
    end else begin
      win_lsu = lsu_pend;
    end
    last_owner = win_lsu ? OWN_LSU : OWN_IFU;
    e.owner = win_lsu ? OWN_LSU : OWN_IFU;
    e.addr  = win_lsu ? lsu_a : ifu_a;
    e.wen   = win_lsu ? lsu_w : 1'b0;
    e.wdata = win_lsu ? lsu_d : 32'h0;
    e.wstrb = win_lsu ? lsu_s : 4'h0;
    e.rdata = rd;
    e.dly_ready = 4'(dr);
    e.dly_resp  = 4'(dl);
    exp_q.push_back(e);
    slv_q.push_back(e);
    tgt_acc = acc_cnt + 1;
    tgt_done = done_cnt + 1;
    n = 0;
    while (acc_cnt != tgt_acc) begin
      if (n == 40) begin
        failures++;
        $display("FAIL accept_timeout actual=none required=accept");
        finish_run();
      end
      @(negedge clk);
      #6;
      n++;
    end
    @(negedge clk);
    if (win_lsu) begin
      lsu_req_valid = 1'b0;
      lsu_pend = 0;
    end else begin
      ifu_req_valid = 1'b0;
      ifu_pend = 0;
    end
    #6;
    n = 0;
    while (done_cnt != tgt_done) begin
      if (n == 60) begin
        failures++;
        $display("FAIL resp_timeout actual=none required=resp_valid");
        finish_run();
      end
      @(negedge clk);
      #6;
      n++;
    end
  endtask

  task automatic drain();
    while (ifu_pend || lsu_pend)
      run_one($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    slave_en = 1'b1;
    last_owner = OWN_LSU;

    do_reset();
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    check("rst_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    @(negedge clk);
    mon_track = 1;

    // Tie: both masters valid for four transactions straight after reset.
    for (int i = 0; i < 4; i++) begin
      set_ifu($urandom & 32'hFFFF_FFFC);
      rand_lsu();
      run_one($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
    drain();

    set_ifu(32'h8000_0000);
    run_one(0, 0, 32'h0010_0073);
    set_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    run_one(0, 0, $urandom);
    set_lsu(32'h8000_2000, 1'b0, 32'h0, 4'hF);
    run_one(4, 2, 32'h1234_5678);

    // Stray mem_rvalid while idle.
    @(negedge clk);
    mon_track = 0;
    slave_en = 0;
    man_rvalid = 1'b1;
    man_rdata = 32'h0BAD_0BAD;
    #1;
    check("stray_state", dbg_state, ST_IDLE);
    check("stray_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    check("stray_state_after", dbg_state, ST_IDLE);
    check("stray_mem_valid", mem_valid, 0);

    // Reset while waiting for the slave response.
    @(negedge clk);
    ifu_addr = 32'h8000_0040;
    ifu_req_valid = 1'b1;
    #1;
    check("rw_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    man_ready = 1'b1;
    #1;
    check("rw_req_state", dbg_state, ST_REQ);
    check("rw_mem_valid", mem_valid, 1);
    check("rw_mem_addr", mem_addr, 32'h8000_0040);
    @(negedge clk);
    man_ready = 1'b0;
    #1;
    check("rw_wait_state", dbg_state, ST_WAIT);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_owner = OWN_LSU;
    man_rvalid = 1'b1;
    man_rdata = 32'h5555_AAAA;
    #1;
    check("rw_post_state", dbg_state, ST_IDLE);
    check("rw_post_mem_valid", mem_valid, 0);
    check("rw_post_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    check("rw_post_mem_addr", mem_addr, 0);
    @(negedge clk);
    man_rvalid = 1'b0;
    @(negedge clk);
    slave_en = 1;
    mon_track = 1;
    set_ifu(32'h8000_0080);
    run_one(1, 1, $urandom);

    // Random mixed traffic.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 7) set_ifu($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) < 7) rand_lsu();
      run_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    drain();

    @(negedge clk);
    @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    finish_run();
  end

endmodule
